aim_sched: RTL and testbench
============================

# aim_sched

Sequencing controller for the associative index-match (AIM) array. It holds the 32 weight-channel indices and fires one AIM run per job, sampling the 32-lane match results at the fixed AIM encode cycles. It keeps the first hit per lane, then drains the hits as a valid/ready stream of (lane, IA position) pairs to the sparse-MAC address generator. It sits between the weight-index loader and the AIM instance.

## Interface
- LANES, 32, weight lanes / IA channels per iteration
- W_C_BITWIDTH, 6, weight channel index width
- MAX_ITER, 8, max AIM iterations per job (IA_CHANNEL/LANES)
- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low, sampled on rising i_clk
- i_wr_en / i_wr_lane / i_wr_word  in  1/5/W_C_BITWIDTH  weight-index register write
- i_start  in  1  job start; accepted only in IDLE
- i_num_iter  in  4  iterations for this job, 1..MAX_ITER; sampled with i_start
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse at job end
- o_hit_cnt  out  6  lanes that hit in the last job; valid from o_done until next start
- o_aim_start  out  1  one-cycle AIM start
- o_aim_ite  out  4  i_num_iter-1, registered, held for whole job
- o_aim_word  out  LANES×W_C_BITWIDTH  weight-index registers to AIM
- i_aim_valid  in  LANES  AIM per-lane valid
- i_aim_pos  in  LANES×9  AIM per-lane IA position
- o_m_valid / i_m_ready  out/in  1/1  match-stream handshake
- o_m_lane  out  5  lane of the current match
- o_m_pos  out  9  IA position of the current match

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Writes update weight register i_wr_lane. Writes in RUN/DRAIN are ignored, so o_aim_word stays stable.
  - i_start with i_num_iter in 1..8: latch N, clear the hit mask and pos regs, go to RUN.
  - i_num_iter 0 or >8: start ignored, no pulse.
- RUN:
  - Cycle counter c = 0 on the first RUN cycle. o_aim_start=1 only at c=0.
  - Capture cycles are c = 3+2k, k = 0..N-1. Only these cycles sample i_aim_valid/i_aim_pos; the AIM lines may be undriven elsewhere.
  - At a capture cycle, for each lane with i_aim_valid=1 and hit=0: set hit and store pos.
  - Lanes already hit ignore later valids, because the AIM match flag is sticky.
  - After capture k=N-1 (c=2N+1), go to DRAIN.
- DRAIN:
  - o_m_valid=1 while any undrained hit exists. o_m_lane is the lowest-index undrained hit lane; o_m_pos is its stored pos.
  - On o_m_valid&&i_m_ready, clear that lane's pending bit. The next lowest lane is presented the following cycle.
  - Lane/pos are stable while valid is high and ready is low.
  - When no pending hits remain (including zero hits), the next cycle enters IDLE and o_done=1 for that one cycle.
- o_hit_cnt = popcount of the hit mask, registered at DRAIN entry.

## Timing
- Reset: state IDLE, weight regs 0, hit/pending masks 0, o_busy 0, o_done 0, o_aim_start 0, o_aim_ite 0, o_m_valid 0, o_m_lane 0, o_m_pos 0, o_hit_cnt 0.
- Reset mid-job: abort next edge, no o_done, stream drops immediately.
- i_start at edge t gives o_aim_start at cycle t+1 and o_busy from t+1. i_start while busy is ignored.
- Job length with H hits and ready held high: RUN = 2N+2 cycles, DRAIN = H cycles (min 1 cycle to detect empty when H=0). o_done follows.
- Throughput: one match per cycle with ready held high.
- Job with H=0 and N=1: RUN cycles c=0..3, DRAIN 1 cycle, o_done on the following cycle.
- i_wr_en together with i_start in IDLE: the write takes effect and the job uses the new value.

## Structure
- Package aim_pkg:
  - constants LANES, W_C_BITWIDTH, MAX_ITER, POS_W=9
  - state enum {S_IDLE, S_RUN, S_DRAIN}
  - capture-offset constants CAP_FIRST=3, CAP_STRIDE=2
- Sub-module lane_pick: 32-bit find-first-set giving index (5b) and any-flag, purely combinational. Used in DRAIN.
- Hit-mask and pos storage are flops in aim_sched. No SRAM.

## Test plan
- Reset, then write lanes 0..31 with index=lane; start N=1. Model drives lane 5 valid pos 12 and lane 20 valid pos 3 at c=3. Expect stream (5,12), (20,3), o_hit_cnt=2, o_done at 2·1+2+2+1 cycles after start.
- N=3. Lane 7 valid pos 40 at k=1; lane 7 valid pos 0 (sticky) at k=2. Expect a single (7,40).
- Random valid values on non-capture cycles. Expect no effect on the hit mask.
- i_m_ready toggled 0/1 randomly with 4 hits. Expect lane/pos stable under backpressure and ascending lane order.
- N=0 start, then i_start while busy. Expect both ignored; o_aim_start pulses once per accepted job.
- i_rst_n low during DRAIN. Expect all outputs at reset values next cycle, no o_done; a fresh job then completes normally.

Source files
------------

// File: rtl/aim_pkg.sv
// aim_pkg: shared constants, types and helpers for the AIM sequencing controller.
//   LANES / W_C_BITWIDTH / MAX_ITER / POS_W : array geometry
//   CAP_FIRST / CAP_STRIDE                  : AIM encode cycles, relative to the AIM start cycle
//   state_t                                 : controller states
//   popcount()                              : number of set lanes in a lane mask
package aim_pkg;

  localparam int LANES        = 32;
  localparam int W_C_BITWIDTH = 6;
  localparam int MAX_ITER     = 8;
  localparam int POS_W        = 9;
  localparam int LANE_W       = 5;
  localparam int ITER_W       = 4;
  localparam int CNT_W        = 5;
  localparam int HIT_CNT_W    = 6;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CAP_FIRST  = cnt_t'(3);
  localparam cnt_t CAP_STRIDE = cnt_t'(2);

  localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Count of set bits in a lane mask; 32 hits still fits in 6 bits.
  function automatic logic [HIT_CNT_W-1:0] popcount(input logic [LANES-1:0] mask);
    logic [HIT_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + HIT_CNT_W'(mask[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/aim_sched_lane_pick.sv
// lane_pick: combinational find-first-set over the pending-hit mask.
//   i_mask : one bit per lane
//   o_idx  : lowest set lane index (0 when the mask is empty)
//   o_any  : mask is non-zero
module lane_pick
  import aim_pkg::*;
(
  input  logic [LANES-1:0]  i_mask,
  output logic [LANE_W-1:0] o_idx,
  output logic              o_any
);

  // Scanning from the top lane down lets the lowest set lane win last.
  always_comb begin
    o_idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_idx = LANE_W'(i);
      end
    end
  end

  assign o_any = |i_mask;

endmodule

// File: rtl/aim_sched.sv
// aim_sched: sequencing controller for the associative index-match array.
//   i_clk, i_rst_n                 : clock, synchronous active-low reset
//   i_wr_en/i_wr_lane/i_wr_word    : weight-index register write (IDLE only)
//   i_start/i_num_iter             : job start with iteration count 1..MAX_ITER
//   o_busy/o_done/o_hit_cnt        : job status
//   o_aim_start/o_aim_ite/o_aim_word : AIM control and weight indices
//   i_aim_valid/i_aim_pos          : AIM per-lane match results
//   o_m_valid/i_m_ready/o_m_lane/o_m_pos : match stream to the address generator
module aim_sched
  import aim_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_wr_en,
  input  logic [LANE_W-1:0]             i_wr_lane,
  input  logic [W_C_BITWIDTH-1:0]       i_wr_word,
  input  logic                          i_start,
  input  logic [ITER_W-1:0]             i_num_iter,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [HIT_CNT_W-1:0]          o_hit_cnt,
  output logic                          o_aim_start,
  output logic [ITER_W-1:0]             o_aim_ite,
  output logic [LANES*W_C_BITWIDTH-1:0] o_aim_word,
  input  logic [LANES-1:0]              i_aim_valid,
  input  logic [LANES*POS_W-1:0]        i_aim_pos,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [LANE_W-1:0]             o_m_lane,
  output logic [POS_W-1:0]              o_m_pos
);

  state_t                  state, state_nxt;
  cnt_t                    c, last_c;
  logic [W_C_BITWIDTH-1:0] wreg [LANES];
  logic [POS_W-1:0]        pos_reg [LANES];
  logic [LANES-1:0]        hit, hit_nxt, pending, pop_mask;
  logic                    start_ok, capture, run_end, drain_end;
  logic [LANE_W-1:0]       pick_idx;
  logic                    pick_any;

  lane_pick u_lane_pick (
    .i_mask (pending),
    .o_idx  (pick_idx),
    .o_any  (pick_any)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_word
    assign o_aim_word[g*W_C_BITWIDTH +: W_C_BITWIDTH] = wreg[g];
  end

  // Match stream: present the lowest pending lane and build the one-hot
  // mask of the lane retired by this cycle's handshake.
  always_comb begin
    o_m_valid = (state == S_DRAIN) && pick_any;
    o_m_lane  = '0;
    o_m_pos   = '0;
    pop_mask  = '0;
    if (o_m_valid) begin
      o_m_lane = pick_idx;
      o_m_pos  = pos_reg[pick_idx];
      if (i_m_ready) begin
        pop_mask[pick_idx] = 1'b1;
      end
    end
  end

  // First hit per lane wins; later valids on an already-hit lane are ignored
  // because the AIM match flag stays set once raised.
  always_comb begin
    hit_nxt = hit;
    if (capture) begin
      hit_nxt = hit | i_aim_valid;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-state strobes. Capture cycles sit at
  // CAP_FIRST + k*CAP_STRIDE; the mask test relies on the stride being a
  // power of two. DRAIN leaves on the cycle its last pending lane retires.
  always_comb begin
    state_nxt   = state;
    start_ok    = 1'b0;
    capture     = 1'b0;
    run_end     = 1'b0;
    drain_end   = 1'b0;
    o_busy      = (state != S_IDLE);
    o_aim_start = (state == S_RUN) && (c == '0);
    case (state)
      S_IDLE: begin
        if (i_start && (i_num_iter != '0) && (i_num_iter <= MAX_ITER_V)) begin
          start_ok  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        capture = (c >= CAP_FIRST) &&
                  (((c - CAP_FIRST) & (CAP_STRIDE - cnt_t'(1))) == '0);
        if (c == last_c) begin
          run_end   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((pending & ~pop_mask) == '0) begin
          drain_end = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: weight registers, run counter, hit/pending masks, stored
  // positions and job status. The final capture cycle feeds hit_nxt
  // straight into the pending mask and the hit count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      c         <= '0;
      last_c    <= '0;
      hit       <= '0;
      pending   <= '0;
      o_done    <= 1'b0;
      o_hit_cnt <= '0;
      o_aim_ite <= '0;
      for (int i = 0; i < LANES; i++) begin
        wreg[i]    <= '0;
        pos_reg[i] <= '0;
      end
    end else begin
      o_done <= drain_end;
      if ((state == S_IDLE) && i_wr_en) begin
        wreg[i_wr_lane] <= i_wr_word;
      end
      if (start_ok) begin
        c         <= '0;
        last_c    <= CAP_FIRST + CAP_STRIDE * cnt_t'(i_num_iter - ITER_W'(1));
        o_aim_ite <= i_num_iter - ITER_W'(1);
        hit       <= '0;
        pending   <= '0;
        for (int i = 0; i < LANES; i++) begin
          pos_reg[i] <= '0;
        end
      end else if (state == S_RUN) begin
        c   <= c + cnt_t'(1);
        hit <= hit_nxt;
        for (int i = 0; i < LANES; i++) begin
          if (capture && i_aim_valid[i] && !hit[i]) begin
            pos_reg[i] <= i_aim_pos[i*POS_W +: POS_W];
          end
        end
        if (run_end) begin
          pending   <= hit_nxt;
          o_hit_cnt <= popcount(hit_nxt);
        end
      end else if (state == S_DRAIN) begin
        pending <= pending & ~pop_mask;
      end
    end
  end

endmodule

// File: tb/tb_aim_sched.sv
// tb_aim_sched: self-checking bench for aim_sched.
//   Table of jobs (iterations, AIM match events, expected stream) applied in a
//   loop; expected matches go into a scoreboard queue at job start and are
//   popped on every stream handshake. Hand-written sequences cover illegal
//   starts, writes around a job and reset during DRAIN.
module tb_aim_sched;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_wr_en;
  logic [4:0]   i_wr_lane;
  logic [5:0]   i_wr_word;
  logic         i_start;
  logic [3:0]   i_num_iter;
  logic         o_busy;
  logic         o_done;
  logic [5:0]   o_hit_cnt;
  logic         o_aim_start;
  logic [3:0]   o_aim_ite;
  logic [191:0] o_aim_word;
  logic [31:0]  i_aim_valid;
  logic [287:0] i_aim_pos;
  logic         o_m_valid;
  logic         i_m_ready;
  logic [4:0]   o_m_lane;
  logic [8:0]   o_m_pos;

  aim_sched dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_lane   (i_wr_lane),
    .i_wr_word   (i_wr_word),
    .i_start     (i_start),
    .i_num_iter  (i_num_iter),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_hit_cnt   (o_hit_cnt),
    .o_aim_start (o_aim_start),
    .o_aim_ite   (o_aim_ite),
    .o_aim_word  (o_aim_word),
    .i_aim_valid (i_aim_valid),
    .i_aim_pos   (i_aim_pos),
    .o_m_valid   (o_m_valid),
    .i_m_ready   (i_m_ready),
    .o_m_lane    (o_m_lane),
    .o_m_pos     (o_m_pos)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int n;
    int rr;
    int noise;
    int restart;
    int nev;
    int ev_k[4];
    int ev_lane[4];
    int ev_pos[4];
    int nexp;
    int exp_lane[4];
    int exp_pos[4];
  } vec_t;

  vec_t vecs[8];
  int   nvec;
  int   sb_lane[$];
  int   sb_pos[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Compare one value and report a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int n, input int rr, input int noise, input int restart);
    vecs[nvec].n       = n;
    vecs[nvec].rr      = rr;
    vecs[nvec].noise   = noise;
    vecs[nvec].restart = restart;
    vecs[nvec].nev     = 0;
    vecs[nvec].nexp    = 0;
    nvec++;
  endtask

  task automatic add_ev(input int k, input int lane, input int pos);
    int e;
    e = vecs[nvec-1].nev;
    vecs[nvec-1].ev_k[e]    = k;
    vecs[nvec-1].ev_lane[e] = lane;
    vecs[nvec-1].ev_pos[e]  = pos;
    vecs[nvec-1].nev        = e + 1;
  endtask

  task automatic add_exp(input int lane, input int pos);
    int e;
    e = vecs[nvec-1].nexp;
    vecs[nvec-1].exp_lane[e] = lane;
    vecs[nvec-1].exp_pos[e]  = pos;
    vecs[nvec-1].nexp        = e + 1;
  endtask

  // AIM model: drive table events on capture cycles only; other cycles
  // carry either zeros or random noise.
  task automatic drive_aim(input vec_t v, input int c);
    int k;
    i_aim_valid = '0;
    i_aim_pos   = '0;
    if (c >= 3 && (c % 2) == 1 && (c - 3) / 2 < v.n) begin
      k = (c - 3) / 2;
      for (int e = 0; e < v.nev; e++) begin
        if (v.ev_k[e] == k) begin
          i_aim_valid[v.ev_lane[e]]      = 1'b1;
          i_aim_pos[v.ev_lane[e]*9 +: 9] = 9'(v.ev_pos[e]);
        end
      end
    end else if (v.noise != 0) begin
      i_aim_valid = $urandom();
      for (int l = 0; l < 32; l++) begin
        i_aim_pos[l*9 +: 9] = 9'($urandom());
      end
    end
  endtask

  // Run one table job: push expected stream, start, model AIM, check the
  // stream against the scoreboard, then check status at o_done.
  task automatic applyStimulus(input int vi);
    vec_t       v;
    int         cyc, done_cyc, starts, exp_len, h;
    logic       pv, pr;
    logic [4:0] pl;
    logic [8:0] pp;
    v = vecs[vi];
    sb_lane.delete();
    sb_pos.delete();
    for (int e = 0; e < v.nexp; e++) begin
      sb_lane.push_back(v.exp_lane[e]);
      sb_pos.push_back(v.exp_pos[e]);
    end
    i_start    = 1'b1;
    i_num_iter = 4'(v.n);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    checkOutput("aim_ite", o_aim_ite, v.n - 1);
    checkOutput("busy_after_start", o_busy, 1);
    checkOutput("aim_start_t1", o_aim_start, 1);
    cyc = 1; starts = 0; done_cyc = 0; pv = 0; pr = 0; pl = 0; pp = 0;
    while (done_cyc == 0 && cyc < 400) begin
      drive_aim(v, cyc - 1);
      if (o_aim_start) starts++;
      if (pv && !pr) begin
        checkOutput("hold_valid", o_m_valid, 1);
        checkOutput("hold_lane", o_m_lane, pl);
        checkOutput("hold_pos", o_m_pos, pp);
      end
      i_m_ready = (v.rr != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.restart != 0) begin
        i_start    = (cyc == 3);
        i_num_iter = 4'd2;
      end
      if (o_m_valid && i_m_ready) begin
        if (sb_lane.size() == 0) begin
          checkOutput("unexpected_match", o_m_valid, 0);
        end else begin
          checkOutput("m_lane", o_m_lane, sb_lane.pop_front());
          checkOutput("m_pos", o_m_pos, sb_pos.pop_front());
        end
      end
      pv = o_m_valid; pr = i_m_ready; pl = o_m_lane; pp = o_m_pos;
      if (o_done) begin
        done_cyc = cyc;
      end else begin
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    i_start     = 1'b0;
    i_aim_valid = '0;
    i_aim_pos   = '0;
    if (done_cyc == 0) checkOutput("done_timeout", o_done, 1);
    h = (v.nexp > 0) ? v.nexp : 1;
    exp_len = 2 * v.n + 3 + h;
    if (v.rr == 0) checkOutput("done_cycle", done_cyc, exp_len);
    checkOutput("hit_cnt", o_hit_cnt, v.nexp);
    checkOutput("busy_at_done", o_busy, 0);
    checkOutput("aim_start_count", starts, 1);
    checkOutput("sb_drained", sb_lane.size(), 0);
    @(posedge i_clk); #1;
    checkOutput("done_one_cycle", o_done, 0);
    checkOutput("hit_cnt_hold", o_hit_cnt, v.nexp);
  endtask

  logic [191:0] exp_word;
  int           cyc, seen;

  initial begin
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_wr_lane = '0; i_wr_word = '0;
    i_start = 1'b0; i_num_iter = '0; i_aim_valid = '0; i_aim_pos = '0;
    i_m_ready = 1'b0; nvec = 0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_aim_start", o_aim_start, 0);
    checkOutput("rst_aim_ite", o_aim_ite, 0);
    checkOutput("rst_m_valid", o_m_valid, 0);
    checkOutput("rst_m_lane", o_m_lane, 0);
    checkOutput("rst_m_pos", o_m_pos, 0);
    checkOutput("rst_hit_cnt", o_hit_cnt, 0);
    checkOutput("rst_aim_word", o_aim_word, 0);
    i_rst_n = 1'b1;

    exp_word = '0;
    for (int l = 0; l < 32; l++) begin
      i_wr_en = 1'b1; i_wr_lane = 5'(l); i_wr_word = 6'(l);
      exp_word[l*6 +: 6] = 6'(l);
      @(posedge i_clk); #1;
    end
    i_wr_en = 1'b0;
    checkOutput("aim_word_load", o_aim_word, exp_word);

    // Job table: n, random ready, noise, restart-while-busy.
    add_vec(1, 0, 0, 0);
    add_ev(0, 5, 12); add_ev(0, 20, 3);
    add_exp(5, 12); add_exp(20, 3);
    add_vec(3, 0, 0, 0);
    add_ev(1, 7, 40); add_ev(2, 7, 0);
    add_exp(7, 40);
    add_vec(2, 0, 1, 1);
    add_ev(0, 31, 511); add_ev(1, 0, 1);
    add_exp(0, 1); add_exp(31, 511);
    add_vec(4, 1, 0, 0);
    add_ev(3, 30, 100); add_ev(0, 2, 7); add_ev(2, 17, 255); add_ev(1, 9, 9);
    add_exp(2, 7); add_exp(9, 9); add_exp(17, 255); add_exp(30, 100);
    add_vec(8, 0, 1, 0);
    add_vec(1, 0, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      applyStimulus(i);
    end

    // Illegal iteration counts are ignored.
    i_start = 1'b1; i_num_iter = 4'd0;
    @(posedge i_clk); #1;
    checkOutput("n0_busy", o_busy, 0);
    checkOutput("n0_aim_start", o_aim_start, 0);
    i_num_iter = 4'd9;
    @(posedge i_clk); #1;
    checkOutput("n9_busy", o_busy, 0);
    checkOutput("n9_aim_start", o_aim_start, 0);
    i_start = 1'b0;

    // Write together with start lands; writes while busy are dropped.
    i_wr_en = 1'b1; i_wr_lane = 5'd4; i_wr_word = 6'd50;
    i_start = 1'b1; i_num_iter = 4'd1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    checkOutput("start_with_wr", o_aim_start, 1);
    checkOutput("wr_with_start", o_aim_word[4*6 +: 6], 50);
    i_wr_lane = 5'd3; i_wr_word = 6'd63;
    repeat (2) @(posedge i_clk);
    #1;
    i_wr_en = 1'b0;
    checkOutput("wr_ignored_busy", o_aim_word[3*6 +: 6], 3);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (o_done) seen = 1;
      else begin @(posedge i_clk); #1; end
    end
    checkOutput("wr_job_done", seen, 1);
    checkOutput("wr_job_hit_cnt", o_hit_cnt, 0);

    // Reset asserted while DRAIN is stalled by backpressure.
    i_m_ready = 1'b0;
    i_start = 1'b1; i_num_iter = 4'd1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cyc = 1;
    while (!o_m_valid && cyc < 20) begin
      i_aim_valid = '0; i_aim_pos = '0;
      if (cyc == 4) begin
        i_aim_valid[1] = 1'b1; i_aim_pos[1*9 +: 9] = 9'd33;
        i_aim_valid[2] = 1'b1; i_aim_pos[2*9 +: 9] = 9'd44;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_aim_valid = '0; i_aim_pos = '0;
    checkOutput("pre_rst_valid", o_m_valid, 1);
    checkOutput("pre_rst_lane", o_m_lane, 1);
    checkOutput("pre_rst_pos", o_m_pos, 33);
    checkOutput("pre_rst_hit_cnt", o_hit_cnt, 2);
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("mid_rst_valid", o_m_valid, 0);
    checkOutput("mid_rst_busy", o_busy, 0);
    checkOutput("mid_rst_done", o_done, 0);
    checkOutput("mid_rst_hit_cnt", o_hit_cnt, 0);
    checkOutput("mid_rst_lane", o_m_lane, 0);
    checkOutput("mid_rst_pos", o_m_pos, 0);
    checkOutput("mid_rst_word", o_aim_word, 0);
    i_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge i_clk); #1;
      if (o_done) seen++;
    end
    checkOutput("no_done_after_rst", seen, 0);

    applyStimulus(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
